counter_updown_mod: RTL and testbench

Parametrised successor to the fixed 32-bit up/down counter with parallel load. Adds the following:
- configurable width and modulus
- wrap or saturate mode
- count enable and synchronous reset
- combinational terminal-count output for cascading stages
- registered boundary pulse
Used as the general timer/counter primitive in later labs (BCD digits, clock dividers, multi-stage cascades).

---
 rtl/counter_pkg.sv | 22 ++
 rtl/counter_next.sv | 45 ++++
 rtl/counter_updown_mod.sv | 67 ++++++
 tb/tb_counter_updown_mod.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/counter_pkg.sv
// Shared constants and parameter-legality helper for the up/down counter family.
package counter_pkg;

    localparam logic DIR_UP    = 1'b1;
    localparam logic DIR_DOWN  = 1'b0;
    localparam int   MODE_WRAP = 0;
    localparam int   MODE_SAT  = 1;

    // True when the width fits 1..32, the modulus fits the width, the reset value
    // lies inside the count range and the mode is one of the two known modes.
    function automatic bit params_legal(input int width,
                                        input longint unsigned mod_max,
                                        input longint unsigned reset_val,
                                        input int saturate);
        longint unsigned lim;
        lim = (64'd1 << width) - 64'd1;
        return (width >= 1) && (width <= 32) && (mod_max <= lim) &&
               (reset_val <= mod_max) &&
               ((saturate == MODE_WRAP) || (saturate == MODE_SAT));
    endfunction

endpackage

// File: rtl/counter_next.sv
// Combinational next-count and boundary detection for the up/down counter.
module counter_next
    import counter_pkg::*;
#(
    parameter int               WIDTH    = 32,
    parameter logic [WIDTH-1:0] MAX_VAL  = '1,
    parameter int               SATURATE = MODE_WRAP
) (
    input  logic [WIDTH-1:0] i_cnt,
    input  logic             i_s,
    output logic [WIDTH-1:0] o_next_cnt,
    output logic             o_boundary
);

    localparam logic [WIDTH:0] LP_ONE = {{WIDTH{1'b0}}, 1'b1};
    localparam logic [WIDTH:0] LP_MAX = {1'b0, MAX_VAL};

    logic [WIDTH:0] w_ext;
    logic [WIDTH:0] w_inc;
    logic [WIDTH:0] w_dec;

    // One extra bit so an increment past MAX_VAL or a decrement below zero is
    // visible without relying on a 2**WIDTH wrap.
    assign w_ext = {1'b0, i_cnt};
    assign w_inc = w_ext + LP_ONE;
    assign w_dec = w_ext - LP_ONE;

    assign o_boundary = (i_s == DIR_UP) ? (i_cnt == MAX_VAL) : (i_cnt == '0);

    always_comb begin
        o_next_cnt = i_cnt;
        if (i_s == DIR_UP) begin
            if (w_inc > LP_MAX)
                o_next_cnt = (SATURATE == MODE_SAT) ? i_cnt : '0;
            else
                o_next_cnt = w_inc[WIDTH-1:0];
        end else if (i_s == DIR_DOWN) begin
            if (w_dec[WIDTH])
                o_next_cnt = (SATURATE == MODE_SAT) ? i_cnt : MAX_VAL;
            else
                o_next_cnt = w_dec[WIDTH-1:0];
        end
    end

endmodule

// File: rtl/counter_updown_mod.sv
// Parametrised up/down counter with clamped parallel load, wrap/saturate mode,
// combinational terminal count for cascading and a registered boundary pulse.
module counter_updown_mod
    import counter_pkg::*;
#(
    parameter int              WIDTH     = 32,
    parameter longint unsigned MOD_MAX   = (64'd1 << WIDTH) - 64'd1,
    parameter int              SATURATE  = MODE_WRAP,
    parameter longint unsigned RESET_VAL = 64'd0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             s,
    input  logic             Load,
    input  logic [WIDTH-1:0] PData,
    output logic [WIDTH-1:0] cnt,
    output logic             tc,
    output logic             Rc
);

    localparam logic [WIDTH-1:0] LP_MAX = MOD_MAX[WIDTH-1:0];
    localparam logic [WIDTH-1:0] LP_RST = RESET_VAL[WIDTH-1:0];

    if (!params_legal(WIDTH, MOD_MAX, RESET_VAL, SATURATE)) begin : g_bad_params
        $error("counter_updown_mod: illegal WIDTH/MOD_MAX/RESET_VAL/SATURATE combination");
    end

    logic [WIDTH-1:0] r_cnt;
    logic             r_rc;
    logic [WIDTH-1:0] w_next;
    logic             w_bound;
    logic [WIDTH-1:0] w_load_val;

    counter_next #(
        .WIDTH    (WIDTH),
        .MAX_VAL  (LP_MAX),
        .SATURATE (SATURATE)
    ) u_next (
        .i_cnt      (r_cnt),
        .i_s        (s),
        .o_next_cnt (w_next),
        .o_boundary (w_bound)
    );

    assign w_load_val = (PData > LP_MAX) ? LP_MAX : PData;

    assign tc  = en & w_bound;
    assign cnt = r_cnt;
    assign Rc  = r_rc;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= LP_RST;
            r_rc  <= 1'b0;
        end else if (Load) begin
            r_cnt <= w_load_val;
            r_rc  <= 1'b0;
        end else if (en) begin
            r_cnt <= w_next;
            r_rc  <= tc;
        end else begin
            r_rc  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_counter_updown_mod.sv
// Checks wrap, saturate and cascaded counter instances against a behavioural model.
module tb_counter_updown_mod;

    logic       clk = 1'b1;
    logic       rst, en, s, load;
    logic [3:0] pdata;
    logic       casc_rst, casc_en;

    logic [3:0] w_cnt, s_cnt, u_cnt, t_cnt;
    logic       w_tc, w_rc, s_tc, s_rc, u_tc, u_rc, t_tc, t_rc;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    counter_updown_mod #(.WIDTH(4), .MOD_MAX(9), .SATURATE(0), .RESET_VAL(0)) u_wrap (
        .clk(clk), .rst(rst), .en(en), .s(s), .Load(load), .PData(pdata),
        .cnt(w_cnt), .tc(w_tc), .Rc(w_rc));

    counter_updown_mod #(.WIDTH(4), .MOD_MAX(9), .SATURATE(1), .RESET_VAL(0)) u_sat (
        .clk(clk), .rst(rst), .en(en), .s(s), .Load(load), .PData(pdata),
        .cnt(s_cnt), .tc(s_tc), .Rc(s_rc));

    counter_updown_mod #(.WIDTH(4), .MOD_MAX(9), .SATURATE(0), .RESET_VAL(0)) u_units (
        .clk(clk), .rst(casc_rst), .en(casc_en), .s(1'b1), .Load(1'b0), .PData(4'd0),
        .cnt(u_cnt), .tc(u_tc), .Rc(u_rc));

    counter_updown_mod #(.WIDTH(4), .MOD_MAX(5), .SATURATE(0), .RESET_VAL(0)) u_tens (
        .clk(clk), .rst(casc_rst), .en(u_tc), .s(1'b1), .Load(1'b0), .PData(4'd0),
        .cnt(t_cnt), .tc(t_tc), .Rc(t_rc));

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d at t=%0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: counts as plain integers in 0..9; the cascade is one
    // integer in 0..59 split into decimal digits.
    int  m_w, m_s, m_wrc, m_src, m_c, m_urc, m_trc;
    bit  mv  = 0;
    bit  mcv = 0;

    function automatic int exp_tc(input int m, input int mx, input logic e, input logic d);
        return (e && (d ? (m == mx) : (m == 0))) ? 1 : 0;
    endfunction

    always @(negedge clk) begin
        if (mv) begin
            chk("wrap_cnt", int'(w_cnt), m_w);
            chk("wrap_rc",  int'(w_rc),  m_wrc);
            chk("wrap_tc",  int'(w_tc),  exp_tc(m_w, 9, en, s));
            chk("sat_cnt",  int'(s_cnt), m_s);
            chk("sat_rc",   int'(s_rc),  m_src);
            chk("sat_tc",   int'(s_tc),  exp_tc(m_s, 9, en, s));
            assert (w_cnt <= 4'd9 && s_cnt <= 4'd9)
            else begin
                failures++;
                $display("FAIL range actual=%0d/%0d required<=9", w_cnt, s_cnt);
            end
        end
        if (mcv) begin
            chk("casc_units", int'(u_cnt), m_c % 10);
            chk("casc_tens",  int'(t_cnt), m_c / 10);
            chk("casc_u_tc",  int'(u_tc),  (casc_en && (m_c % 10 == 9)) ? 1 : 0);
            chk("casc_t_tc",  int'(t_tc),  (casc_en && m_c == 59) ? 1 : 0);
            chk("casc_u_rc",  int'(u_rc),  m_urc);
            chk("casc_t_rc",  int'(t_rc),  m_trc);
        end

        // Predict the state after the coming rising edge from the stable inputs.
        if (rst) begin
            m_w = 0; m_s = 0; m_wrc = 0; m_src = 0; mv = 1;
        end else if (mv) begin
            if (load) begin
                m_w = (int'(pdata) > 9) ? 9 : int'(pdata);
                m_s = m_w; m_wrc = 0; m_src = 0;
            end else if (en) begin
                m_wrc = exp_tc(m_w, 9, en, s);
                m_src = exp_tc(m_s, 9, en, s);
                m_w   = s ? (m_w + 1) % 10 : (m_w + 9) % 10;
                m_s   = s ? ((m_s < 9) ? m_s + 1 : 9) : ((m_s > 0) ? m_s - 1 : 0);
            end else begin
                m_wrc = 0; m_src = 0;
            end
        end

        if (casc_rst) begin
            m_c = 0; m_urc = 0; m_trc = 0; mcv = 1;
        end else if (mcv) begin
            if (casc_en) begin
                m_urc = (m_c % 10 == 9) ? 1 : 0;
                m_trc = (m_c == 59) ? 1 : 0;
                m_c   = (m_c + 1) % 60;
            end else begin
                m_urc = 0;
                m_trc = 0;
            end
        end
    end

    task automatic step(input logic r, input logic l, input logic [3:0] pd,
                        input logic e, input logic d);
        rst = r; load = l; pdata = pd; en = e; s = d;
        @(posedge clk);
        #1;
    endtask

    int t_pulses;

    initial begin
        casc_rst = 1'b1;
        casc_en  = 1'b0;

        // Reset wins over a simultaneous load.
        step(1, 1, 4'd5, 1, 1);
        chk("lit_rst_cnt", int'(w_cnt), 0);
        chk("lit_rst_rc",  int'(w_rc),  0);
        chk("lit_rst_sat", int'(s_cnt), 0);
        for (int i = 1; i <= 3; i++) begin
            step(0, 0, 4'd0, 1, 1);
            chk("lit_up_after_rst", int'(w_cnt), i);
        end

        // Up wrap 8 -> 9 -> 0 -> 1.
        step(0, 1, 4'd8, 0, 1);
        chk("lit_load8", int'(w_cnt), 8);
        step(0, 0, 4'd0, 1, 1);
        chk("lit_wrap9",    int'(w_cnt), 9);
        chk("lit_wrap9_tc", int'(w_tc),  1);
        chk("lit_wrap9_rc", int'(w_rc),  0);
        step(0, 0, 4'd0, 1, 1);
        chk("lit_wrap0",    int'(w_cnt), 0);
        chk("lit_wrap0_rc", int'(w_rc),  1);
        step(0, 0, 4'd0, 1, 1);
        chk("lit_wrap1_rc", int'(w_rc),  0);

        // Clamp and down wrap 1 -> 0 -> 9.
        step(0, 1, 4'd15, 0, 0);
        chk("lit_clamp", int'(w_cnt), 9);
        step(0, 1, 4'd1, 0, 0);
        step(0, 0, 4'd0, 1, 0);
        chk("lit_down0",    int'(w_cnt), 0);
        chk("lit_down0_tc", int'(w_tc),  1);
        step(0, 0, 4'd0, 1, 0);
        chk("lit_down9",    int'(w_cnt), 9);
        chk("lit_down9_rc", int'(w_rc),  1);

        // Saturation holds at the top with Rc high every cycle.
        step(0, 1, 4'd9, 0, 1);
        for (int i = 0; i < 3; i++) begin
            step(0, 0, 4'd0, 1, 1);
            chk("lit_sat_hold", int'(s_cnt), 9);
            chk("lit_sat_rc",   int'(s_rc),  1);
        end
        step(0, 0, 4'd0, 1, 0);
        chk("lit_sat_down",    int'(s_cnt), 8);
        chk("lit_sat_down_rc", int'(s_rc),  0);

        // Enable low holds; load beats enable; reset beats load.
        step(0, 1, 4'd4, 0, 1);
        for (int i = 0; i < 4; i++) step(0, 0, 4'd0, 0, 1);
        chk("lit_hold",    int'(w_cnt), 4);
        chk("lit_hold_rc", int'(w_rc),  0);
        step(0, 1, 4'd2, 1, 1);
        chk("lit_load_pri", int'(w_cnt), 2);
        step(1, 1, 4'd7, 1, 1);
        chk("lit_rst_pri", int'(w_cnt), 0);

        // Randomised traffic, checked every cycle by the model.
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 31) == 0),
                 ($urandom_range(0, 7) == 0),
                 4'($urandom_range(0, 15)),
                 ($urandom_range(0, 3) != 0),
                 ($urandom_range(0, 2) != 0));
        end
        step(0, 0, 4'd0, 0, 1);

        // Two-digit cascade: 00 up to 59 and back to 00.
        casc_rst = 1'b0;
        casc_en  = 1'b1;
        t_pulses = 0;
        for (int i = 1; i <= 60; i++) begin
            @(posedge clk);
            #1;
            if (t_rc) t_pulses++;
            if (i == 59) begin
                chk("lit_casc59_t", int'(t_cnt), 5);
                chk("lit_casc59_u", int'(u_cnt), 9);
            end
        end
        chk("lit_casc00_t",   int'(t_cnt), 0);
        chk("lit_casc00_u",   int'(u_cnt), 0);
        chk("lit_casc_t_rc",  int'(t_rc),  1);
        chk("lit_casc_pulses", t_pulses,   1);
        casc_en = 1'b0;
        @(posedge clk);
        #1;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
